// File: rtl/cache_memory.sv
// cache_memory: storage and lookup datapath of a 4-way set-associative,
// write-back, write-allocate data cache. The external controller sequences
// it; this block only holds lines, compares tags, selects the tree-PLRU
// victim and applies one update per clock edge.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset (clears valid/dirty/PLRU)
//   tag, index       request tag and set select
//   blk_offset       word within the block
//   req_type         0 = read, 1 = write
//   read_en_cache    read-hit access strobe
//   write_en_cache   write-hit strobe, or refill when read_en_mem = 1
//   read_en_mem      refill block present on data_in_mem
//   write_en_mem     victim is being written back; clears its dirty bit
//   data_in_mem      refill block
//   data_in          CPU write word
//   dirty_block_out  victim block when the victim is valid and dirty, else 0
//   hit              tag match on a valid way of the addressed set
//   data_out         registered read word
//   dirty_bit        victim line is valid and dirty
module cache_memory #(
  parameter int WORD_SIZE       = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int BLOCK_SIZE      = WORD_SIZE * WORDS_PER_BLOCK,
  parameter int NUM_BLOCKS      = 64,
  parameter int NUM_WAYS        = 4,
  parameter int TAG_WIDTH       = 25,
  parameter int INDEX_WIDTH     = $clog2(NUM_BLOCKS / NUM_WAYS),
  parameter int OFFSET_WIDTH    = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [TAG_WIDTH-1:0]    tag,
  input  logic [INDEX_WIDTH-1:0]  index,
  input  logic [OFFSET_WIDTH-1:0] blk_offset,
  input  logic                    req_type,
  input  logic                    read_en_cache,
  input  logic                    write_en_cache,
  input  logic                    read_en_mem,
  input  logic                    write_en_mem,
  input  logic [BLOCK_SIZE-1:0]   data_in_mem,
  input  logic [WORD_SIZE-1:0]    data_in,
  output logic [BLOCK_SIZE-1:0]   dirty_block_out,
  output logic                    hit,
  output logic [WORD_SIZE-1:0]    data_out,
  output logic                    dirty_bit
);

  localparam int NUM_SETS = NUM_BLOCKS / NUM_WAYS;
  localparam int LINE_W   = BLOCK_SIZE + TAG_WIDTH + 2;

  // Tree PLRU: b1 picks the half, b2 the way in {0,1}, b3 the way in {2,3}.
  typedef struct packed {
    logic b1;
    logic b2;
    logic b3;
  } plru_t;

  // Line layout: {block, tag, dirty, valid}.
  logic [LINE_W-1:0]    cache [NUM_SETS][NUM_WAYS];
  plru_t                plru  [NUM_SETS];
  logic [WORD_SIZE-1:0] r_data_out;

  logic [NUM_WAYS-1:0]   w_way_hit;
  logic                  w_hit;
  logic [1:0]            w_hit_way;
  logic [1:0]            w_victim_way;
  plru_t                 w_plru;
  logic [LINE_W-1:0]     w_victim_line;
  logic                  w_victim_dirty;
  logic [BLOCK_SIZE-1:0] w_refill_block;
  logic [WORD_SIZE-1:0]  w_refill_word;
  logic [BLOCK_SIZE-1:0] w_hit_block;
  logic [BLOCK_SIZE-1:0] w_write_block;
  logic [WORD_SIZE-1:0]  w_hit_word;

  function automatic plru_t plru_touch(input plru_t p, input logic [1:0] way);
    plru_t n;
    n = p;
    case (way)
      2'd0:    begin n.b1 = 1'b1; n.b2 = 1'b1; end
      2'd1:    begin n.b1 = 1'b1; n.b2 = 1'b0; end
      2'd2:    begin n.b1 = 1'b0; n.b3 = 1'b1; end
      default: begin n.b1 = 1'b0; n.b3 = 1'b0; end
    endcase
    return n;
  endfunction

  // Tag compare; scanning from the top way down lets the lowest hitting way win.
  always_comb begin
    w_way_hit = '0;
    w_hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      w_way_hit[w] = cache[index][w][0] &&
                     (cache[index][w][TAG_WIDTH+1:2] == tag);
    end
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (w_way_hit[NUM_WAYS-1-w]) w_hit_way = 2'(NUM_WAYS-1-w);
    end
    w_hit = |w_way_hit;
  end

  // Victim comes from PLRU state alone; invalid ways are not preferred.
  always_comb begin
    w_plru = plru[index];
    if (w_plru.b1) w_victim_way = w_plru.b3 ? 2'd3 : 2'd2;
    else           w_victim_way = w_plru.b2 ? 2'd1 : 2'd0;
    w_victim_line  = cache[index][w_victim_way];
    w_victim_dirty = w_victim_line[0] & w_victim_line[1];
  end

  // Refill block with the optional write-allocate word merged in.
  always_comb begin
    w_refill_block = data_in_mem;
    if (req_type) w_refill_block[blk_offset*WORD_SIZE +: WORD_SIZE] = data_in;
    w_refill_word = w_refill_block[blk_offset*WORD_SIZE +: WORD_SIZE];
  end

  always_comb begin
    w_hit_block   = cache[index][w_hit_way][LINE_W-1 -: BLOCK_SIZE];
    w_hit_word    = w_hit_block[blk_offset*WORD_SIZE +: WORD_SIZE];
    w_write_block = w_hit_block;
    w_write_block[blk_offset*WORD_SIZE +: WORD_SIZE] = data_in;
  end

  // Reset clears only valid/dirty bits and PLRU; line data and tags keep
  // their contents, so the reset branch touches just the low two bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          cache[s][w][1:0] <= 2'b00;
        end
        plru[s] <= '0;
      end
      r_data_out <= '0;
    end else if (read_en_mem && write_en_cache) begin
      cache[index][w_victim_way] <= {w_refill_block, tag, req_type, 1'b1};
      r_data_out                 <= w_refill_word;
      plru[index]                <= plru_touch(plru[index], w_victim_way);
    end else if (write_en_cache && req_type && w_hit) begin
      cache[index][w_hit_way][LINE_W-1 -: BLOCK_SIZE] <= w_write_block;
      cache[index][w_hit_way][1]                      <= 1'b1;
      plru[index] <= plru_touch(plru[index], w_hit_way);
    end else if (read_en_cache && !req_type && w_hit) begin
      r_data_out  <= w_hit_word;
      plru[index] <= plru_touch(plru[index], w_hit_way);
    end else if (write_en_mem) begin
      cache[index][w_victim_way][1] <= 1'b0;
    end
  end

  assign hit             = w_hit;
  assign data_out        = r_data_out;
  assign dirty_bit       = w_victim_dirty;
  assign dirty_block_out = w_victim_dirty ? w_victim_line[LINE_W-1 -: BLOCK_SIZE] : '0;

endmodule

// File: tb/tb_cache_memory.sv
module tb_cache_memory;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [24:0]  tag;
  logic [3:0]   index;
  logic [1:0]   blk_offset;
  logic         req_type;
  logic         read_en_cache;
  logic         write_en_cache;
  logic         read_en_mem;
  logic         write_en_mem;
  logic [127:0] data_in_mem;
  logic [31:0]  data_in;
  logic [127:0] dirty_block_out;
  logic         hit;
  logic [31:0]  data_out;
  logic         dirty_bit;

  int passed = 0;
  int total  = 0;

  localparam logic [127:0] D0 = 128'hDEADBEEF_55667788_11223344_AABBCCDD;
  localparam logic [127:0] D2 = 128'h0000AAAA_1111BBBB_2222CCCC_3333DDDD;
  localparam logic [127:0] DV = 128'h01234567_89ABCDEF_01234567_89ABCDEF;

  cache_memory #(
    .WORD_SIZE(32),
    .WORDS_PER_BLOCK(4),
    .NUM_BLOCKS(64),
    .NUM_WAYS(4),
    .TAG_WIDTH(25)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tag(tag),
    .index(index),
    .blk_offset(blk_offset),
    .req_type(req_type),
    .read_en_cache(read_en_cache),
    .write_en_cache(write_en_cache),
    .read_en_mem(read_en_mem),
    .write_en_mem(write_en_mem),
    .data_in_mem(data_in_mem),
    .data_in(data_in),
    .dirty_block_out(dirty_block_out),
    .hit(hit),
    .data_out(data_out),
    .dirty_bit(dirty_bit)
  );

  always #5 clk = ~clk;

  task automatic idle();
    read_en_cache  = 1'b0;
    write_en_cache = 1'b0;
    read_en_mem    = 1'b0;
    write_en_mem   = 1'b0;
    req_type       = 1'b0;
  endtask

  task automatic set_addr(input logic [24:0] t, input logic [3:0] i, input logic [1:0] o);
    tag        = t;
    index      = i;
    blk_offset = o;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [24:0] t, input logic [3:0] i, input logic [1:0] o,
                        input logic rt, input logic [31:0] din, input logic [127:0] mem);
    set_addr(t, i, o);
    req_type       = rt;
    data_in        = din;
    data_in_mem    = mem;
    read_en_mem    = 1'b1;
    write_en_cache = 1'b1;
    step();
    idle();
  endtask

  task automatic read(input logic [24:0] t, input logic [3:0] i, input logic [1:0] o);
    set_addr(t, i, o);
    req_type      = 1'b0;
    read_en_cache = 1'b1;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    data_in = '0;
    data_in_mem = '0;
    set_addr(25'h1ABCDE, 4'd0, 2'd3);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    if (hit !== 1'b0) $display("FAIL reset_hit: got %b expected 0", hit); else passed++;
    total++;
    if (data_out !== 32'h0) $display("FAIL reset_data_out: got %h expected 0", data_out); else passed++;
    total++;
    if (dirty_bit !== 1'b0) $display("FAIL reset_dirty_bit: got %b expected 0", dirty_bit); else passed++;
    total++;
    if (dirty_block_out !== 128'h0) $display("FAIL reset_dirty_block: got %h expected 0", dirty_block_out); else passed++;
    total++;
  endtask

  task automatic test_read_hit_way0();
    refill(25'h1ABCDE, 4'd0, 2'd0, 1'b0, 32'h0, D0);
    if (data_out !== 32'hAABBCCDD) $display("FAIL refill_data_out: got %h expected AABBCCDD", data_out); else passed++;
    total++;
    set_addr(25'h1ABCDE, 4'd0, 2'd3);
    read_en_cache = 1'b1;
    #1;
    if (hit !== 1'b1) $display("FAIL rd0_hit: got %b expected 1", hit); else passed++;
    total++;
    step();
    idle();
    if (data_out !== 32'hDEADBEEF) $display("FAIL rd0_data: got %h expected DEADBEEF", data_out); else passed++;
    total++;
  endtask

  task automatic test_read_hit_way1();
    refill(25'h00000AA, 4'd0, 2'd0, 1'b0, 32'h0, D2);
    refill(25'h1ABBDE, 4'd0, 2'd0, 1'b0, 32'h0, D0);
    set_addr(25'h1ABBDE, 4'd0, 2'd2);
    read_en_cache = 1'b1;
    #1;
    if (hit !== 1'b1) $display("FAIL rd1_hit: got %b expected 1", hit); else passed++;
    total++;
    step();
    idle();
    if (data_out !== 32'h55667788) $display("FAIL rd1_data: got %h expected 55667788", data_out); else passed++;
    total++;
    set_addr(25'h1ABCDE, 4'd0, 2'd0);
    #1;
    if (hit !== 1'b1) $display("FAIL way0_kept: got %b expected 1", hit); else passed++;
    total++;
  endtask

  task automatic test_write_hit();
    set_addr(25'h1ABCDE, 4'd0, 2'd2);
    req_type       = 1'b1;
    data_in        = 32'hACF0359E;
    write_en_cache = 1'b1;
    #1;
    if (dirty_bit !== 1'b0) $display("FAIL wr_victim_clean: got %b expected 0", dirty_bit); else passed++;
    total++;
    step();
    idle();
    read(25'h1ABCDE, 4'd0, 2'd2);
    if (data_out !== 32'hACF0359E) $display("FAIL wr_data: got %h expected ACF0359E", data_out); else passed++;
    total++;
    // Touch way1 then way2 so PLRU points at way0, exposing the dirty line.
    read(25'h1ABBDE, 4'd0, 2'd0);
    read(25'h00000AA, 4'd0, 2'd0);
    if (data_out !== 32'h3333DDDD) $display("FAIL way2_data: got %h expected 3333DDDD", data_out); else passed++;
    total++;
    if (dirty_bit !== 1'b1) $display("FAIL wr_dirty_bit: got %b expected 1", dirty_bit); else passed++;
    total++;
    if (dirty_block_out !== 128'hDEADBEEF_ACF0359E_11223344_AABBCCDD)
      $display("FAIL wr_dirty_block: got %h expected DEADBEEFACF0359E11223344AABBCCDD", dirty_block_out);
    else passed++;
    total++;
    write_en_mem = 1'b1;
    step();
    idle();
    if (dirty_bit !== 1'b0) $display("FAIL wb_dirty_bit: got %b expected 0", dirty_bit); else passed++;
    total++;
    if (dirty_block_out !== 128'h0) $display("FAIL wb_dirty_block: got %h expected 0", dirty_block_out); else passed++;
    total++;
  endtask

  task automatic test_read_miss();
    set_addr(25'h0000123, 4'd0, 2'd0);
    read_en_cache = 1'b1;
    #1;
    if (hit !== 1'b0) $display("FAIL miss_hit: got %b expected 0", hit); else passed++;
    total++;
    step();
    idle();
    if (data_out !== 32'h3333DDDD) $display("FAIL miss_hold: got %h expected 3333DDDD", data_out); else passed++;
    total++;
  endtask

  task automatic test_back_to_back();
    set_addr(25'h1ABCDE, 4'd0, 2'd0);
    read_en_cache = 1'b1;
    step();
    if (data_out !== 32'hAABBCCDD) $display("FAIL b2b_rd0: got %h expected AABBCCDD", data_out); else passed++;
    total++;
    blk_offset = 2'd1;
    step();
    if (data_out !== 32'h11223344) $display("FAIL b2b_rd1: got %h expected 11223344", data_out); else passed++;
    total++;
    req_type       = 1'b1;
    write_en_cache = 1'b1;
    data_in        = 32'h5A5A5A5A;
    step();
    req_type       = 1'b0;
    write_en_cache = 1'b0;
    step();
    if (data_out !== 32'h5A5A5A5A) $display("FAIL b2b_wr_rd: got %h expected 5A5A5A5A", data_out); else passed++;
    total++;
    idle();
  endtask

  task automatic test_conflict_clean();
    refill(25'h00C0FF, 4'd3, 2'd0, 1'b0, 32'h0, 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C);
    set_addr(25'h00BEEF, 4'd3, 2'd1);
    #1;
    if (hit !== 1'b0) $display("FAIL cf_hit: got %b expected 0", hit); else passed++;
    total++;
    if (dirty_bit !== 1'b0) $display("FAIL cf_dirty_bit: got %b expected 0", dirty_bit); else passed++;
    total++;
    if (dirty_block_out !== 128'h0) $display("FAIL cf_dirty_block: got %h expected 0", dirty_block_out); else passed++;
    total++;
    refill(25'h00BEEF, 4'd3, 2'd1, 1'b0, 32'h0, 128'h11223344_55667788_99AABBCC_DDEEFF00);
    if (data_out !== 32'h99AABBCC) $display("FAIL cf_refill_word: got %h expected 99AABBCC", data_out); else passed++;
    total++;
    read(25'h00BEEF, 4'd3, 2'd3);
    if (data_out !== 32'h11223344) $display("FAIL cf_read: got %h expected 11223344", data_out); else passed++;
    total++;
    if (dirty_bit !== 1'b0) $display("FAIL cf_clean: got %b expected 0", dirty_bit); else passed++;
    total++;
    set_addr(25'h00C0FF, 4'd3, 2'd0);
    #1;
    if (hit !== 1'b1) $display("FAIL cf_other_kept: got %b expected 1", hit); else passed++;
    total++;
  endtask

  task automatic test_compulsory_write_alloc();
    set_addr(25'h0ABCDE, 4'd2, 2'd0);
    #1;
    if (hit !== 1'b0) $display("FAIL cm_hit: got %b expected 0", hit); else passed++;
    total++;
    refill(25'h00C0FF, 4'd2, 2'd0, 1'b1, 32'h0BADF00D, 128'hCAFEBABE_DEADBEEF_11223344_55667788);
    if (data_out !== 32'h0BADF00D) $display("FAIL cm_alloc_word: got %h expected 0BADF00D", data_out); else passed++;
    total++;
    set_addr(25'h00C0FF, 4'd2, 2'd3);
    #1;
    if (hit !== 1'b1) $display("FAIL cm_new_hit: got %b expected 1", hit); else passed++;
    total++;
    // Fill ways 2, 1, 3 in PLRU order; way0 then becomes the victim.
    refill(25'h11, 4'd2, 2'd0, 1'b0, 32'h0, 128'h11111111_11111112_11111113_11111114);
    refill(25'h22, 4'd2, 2'd0, 1'b0, 32'h0, 128'h22222221_22222222_22222223_22222224);
    refill(25'h33, 4'd2, 2'd0, 1'b0, 32'h0, 128'h33333331_33333332_33333333_33333334);
    if (dirty_bit !== 1'b1) $display("FAIL cm_dirty_bit: got %b expected 1", dirty_bit); else passed++;
    total++;
    if (dirty_block_out !== 128'hCAFEBABE_DEADBEEF_11223344_0BADF00D)
      $display("FAIL cm_dirty_block: got %h expected CAFEBABEDEADBEEF112233440BADF00D", dirty_block_out);
    else passed++;
    total++;
    read(25'h22, 4'd2, 2'd2);
    if (data_out !== 32'h22222222) $display("FAIL cm_way1_read: got %h expected 22222222", data_out); else passed++;
    total++;
  endtask

  task automatic test_dirty_victim_and_reset();
    refill(25'h5, 4'd1, 2'd0, 1'b0, 32'h0, DV);
    set_addr(25'h5, 4'd1, 2'd0);
    req_type       = 1'b1;
    data_in        = 32'h89ABCDEF;
    write_en_cache = 1'b1;
    step();
    idle();
    refill(25'h6, 4'd1, 2'd0, 1'b0, 32'h0, D2);
    refill(25'h7, 4'd1, 2'd0, 1'b0, 32'h0, D2);
    refill(25'h8, 4'd1, 2'd0, 1'b0, 32'h0, D2);
    set_addr(25'h9, 4'd1, 2'd0);
    #1;
    if (hit !== 1'b0) $display("FAIL dv_hit: got %b expected 0", hit); else passed++;
    total++;
    if (dirty_bit !== 1'b1) $display("FAIL dv_dirty_bit: got %b expected 1", dirty_bit); else passed++;
    total++;
    if (dirty_block_out !== DV) $display("FAIL dv_dirty_block: got %h expected %h", dirty_block_out, DV); else passed++;
    total++;
    write_en_mem = 1'b1;
    step();
    idle();
    if (dirty_bit !== 1'b0) $display("FAIL dv_wb_clear: got %b expected 0", dirty_bit); else passed++;
    total++;
    set_addr(25'h5, 4'd1, 2'd0);
    #1;
    if (hit !== 1'b1) $display("FAIL dv_still_valid: got %b expected 1", hit); else passed++;
    total++;
    // Asynchronous reset between edges, with a write pending.
    req_type       = 1'b1;
    write_en_cache = 1'b1;
    data_in        = 32'hFFFFFFFF;
    #1;
    rst_n = 1'b0;
    #1;
    if (hit !== 1'b0) $display("FAIL rst_hit_set1: got %b expected 0", hit); else passed++;
    total++;
    if (data_out !== 32'h0) $display("FAIL rst_data_out: got %h expected 0", data_out); else passed++;
    total++;
    set_addr(25'h1ABCDE, 4'd0, 2'd3);
    #1;
    if (hit !== 1'b0) $display("FAIL rst_hit_set0: got %b expected 0", hit); else passed++;
    total++;
    set_addr(25'h00BEEF, 4'd3, 2'd1);
    #1;
    if (hit !== 1'b0) $display("FAIL rst_hit_set3: got %b expected 0", hit); else passed++;
    total++;
    set_addr(25'h00C0FF, 4'd2, 2'd0);
    #1;
    if (dirty_bit !== 1'b0) $display("FAIL rst_dirty_bit: got %b expected 0", dirty_bit); else passed++;
    total++;
    idle();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_read_hit_way0();
    test_read_hit_way1();
    test_write_hit();
    test_read_miss();
    test_back_to_back();
    test_conflict_clean();
    test_compulsory_write_alloc();
    test_dirty_victim_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
